// File: rtl/nsa_pkg.sv
// nsa_pkg: shared types and helpers for the nibble-serial adder.
// Optional overflow output is enabled by defining NSA_OVERFLOW_EN.
package nsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } nsa_state_t;

  localparam int NIB_W = 4;

  // Nibble counter width for a given operand width.
  function automatic int nsa_cnt_w(input int width);
    int nib;
    nib = width / NIB_W;
    return (nib <= 2) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/add4_slice.sv
// add4_slice: combinational 4-bit ripple-carry adder slice.
// With NSA_OVERFLOW_EN the carry into bit 3 is exported as c3.
module add4_slice
  import nsa_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
`ifdef NSA_OVERFLOW_EN
  ,
  output logic             c3
`endif
);

  logic [NIB_W:0] c;

  // Bit-by-bit ripple chain; c[i] is the carry into bit i.
  always_comb begin
    c = '0;
    s = '0;
    c[0] = cin;
    for (int i = 0; i < NIB_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[NIB_W];

`ifdef NSA_OVERFLOW_EN
  assign c3 = c[NIB_W-1];
`endif

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit A+B+cin, one nibble per clock.
// Define NSA_OVERFLOW_EN to drive out_ovf with signed overflow.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int CNT_W = nsa_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(NIB - 1);

  nsa_state_t state_q;
  nsa_state_t state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [CNT_W-1:0] cnt_q;

  logic [NIB_W-1:0] slice_s;
  logic             slice_cout;
  logic             last;
  logic             accept;
  logic             step;

`ifdef NSA_OVERFLOW_EN
  logic             slice_c3;
  logic             ovf_q;
`endif

  assign last   = (cnt_q == LAST);
  assign accept = (state_q == IDLE) && in_valid;
  assign step   = (state_q == BUSY) && !abort;

  add4_slice u_slice (
    .a    (a_q[NIB_W-1:0]),
    .b    (b_q[NIB_W-1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
`ifdef NSA_OVERFLOW_EN
    ,
    .c3   (slice_c3)
`endif
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: abort wins over the final nibble in BUSY.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = BUSY;
      BUSY: begin
        if (abort)     state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, nibble shifting and carry/result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef NSA_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else if (accept) begin
      a_q     <= in_a;
      b_q     <= in_b;
      carry_q <= in_cin;
      cnt_q   <= '0;
    end else if (step) begin
      a_q     <= a_q >> NIB_W;
      b_q     <= b_q >> NIB_W;
      sum_q   <= {slice_s, sum_q[WIDTH-1:NIB_W]};
      carry_q <= slice_cout;
      if (last) begin
        cout_q <= slice_cout;
`ifdef NSA_OVERFLOW_EN
        ovf_q  <= slice_c3 ^ slice_cout;
`endif
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

`ifdef NSA_OVERFLOW_EN
  assign out_ovf = ovf_q;
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed scoreboard bench, WIDTH=16.
// Overflow expectations follow NSA_OVERFLOW_EN.
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_cin = 1'b0;
  logic         abort = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   acc_cyc = 0;
  int   prev_acc = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic         cin);
    exp_t       e;
    logic [W:0] t;
    t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.sum  = t[W-1:0];
    e.cout = t[W];
`ifdef NSA_OVERFLOW_EN
    e.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
`else
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic         cin);
    int g;
    g = 0;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    sb.push_back(model(a, b, cin));
    while (!in_ready && g < 50) begin
      tick();
      g++;
    end
    chk("issue_in_ready", 32'(in_ready), 32'd1);
    tick();
    prev_acc = acc_cyc;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    chk("busy_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_valid(input string tag, input int lat);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
  endtask

  task automatic score(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_sum"}, 32'(out_sum), 32'(e.sum));
      chk({tag, "_cout"}, 32'(out_cout), 32'(e.cout));
      chk({tag, "_ovf"}, 32'(out_ovf), 32'(e.ovf));
    end
  endtask

  task automatic collect(input string tag);
    wait_valid(tag, 4);
    score(tag);
    out_ready = 1'b1;
    tick();
    chk({tag, "_cons_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_cons_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int   seen;
    exp_t e;

    repeat (2) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_cout", 32'(out_cout), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    rst_n = 1'b1;
    tick();

    issue(16'h1234, 16'h4321, 1'b0);
    collect("basic");
    issue(16'hFFFF, 16'h0001, 1'b0);
    chk("interval_a", 32'(acc_cyc - prev_acc), 32'd6);
    collect("ripple");
    issue(16'h7FFF, 16'h0001, 1'b0);
    chk("interval_b", 32'(acc_cyc - prev_acc), 32'd6);
    collect("sovf");
    issue(16'hFFFF, 16'hFFFF, 1'b1);
    chk("interval_c", 32'(acc_cyc - prev_acc), 32'd6);
    collect("cin_full");

    out_ready = 1'b0;
    issue(16'hBEEF, 16'h1111, 1'b0);
    wait_valid("bp", 4);
    e = sb[0];
    in_valid = 1'b1;
    in_a     = 16'hDEAD;
    in_b     = 16'hDEAD;
    abort    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_sum", 32'(out_sum), 32'(e.sum));
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    abort    = 1'b0;
    score("bp");
    out_ready = 1'b1;
    tick();
    chk("bp_rel_valid", 32'(out_valid), 32'd0);
    chk("bp_rel_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp_no_extra", 32'(in_ready), 32'd1);

    issue(16'h1111, 16'h2222, 1'b0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    void'(sb.pop_back());
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    repeat (8) begin
      if (out_valid) seen++;
      tick();
    end
    chk("abort_no_pulse", 32'(seen), 32'd0);
    issue(16'h0001, 16'h0001, 1'b0);
    collect("post_abort");

    issue(16'hAAAA, 16'h5555, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_sum", 32'(out_sum), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    issue(16'h00FF, 16'h0001, 1'b1);
    collect("post_rst");

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
